// File: rtl/l2_request_port_arbiter.sv
// L2 request port arbiter: round-robin selection among L1-side request
// sources into a single registered request slot toward the L2 cache.

package l2_request_port_arbiter_pkg;

   localparam int unsigned CORE_W = 4;
   localparam int unsigned UNIT_W = 2;
   localparam int unsigned CMD_W  = 2;
   localparam int unsigned ADDR_W = 32;

   typedef struct packed {
      logic              valid;
      logic [CORE_W-1:0] core;
      logic [UNIT_W-1:0] unit;
      logic [CMD_W-1:0]  cmd;
      logic [ADDR_W-1:0] addr;
   } l2req_packet_t;

endpackage

module l2_request_port_arbiter
   import l2_request_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQUESTERS = 3,
   parameter int unsigned CORE_ID        = 0
)(
   input  logic                                clk,
   input  logic                                reset_n,
   input  l2req_packet_t [NUM_REQUESTERS-1:0]  req_packet,
   output logic [NUM_REQUESTERS-1:0]           req_ready,
   output l2req_packet_t                       l2req_packet,
   input  logic                                l2req_ready
);

   localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   l2req_packet_t             r_out;
   logic [PTR_W-1:0]          r_rr_ptr;

   logic                      w_can_load;
   logic                      w_found;
   logic [PTR_W-1:0]          w_winner;
   logic [PTR_W-1:0]          w_next_ptr;
   logic [NUM_REQUESTERS-1:0] w_valid;
   int unsigned               w_scan;
   l2req_packet_t             w_load_pkt;

   // Output slot can take a new packet when empty or being drained this cycle.
   assign w_can_load = !r_out.valid || l2req_ready;

   // Rotating priority search starting at r_rr_ptr, wrapping at the top.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = 0;
      w_valid  = '0;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         w_valid[k] = req_packet[k].valid;
         w_scan = 32'(r_rr_ptr) + k;
         if (w_scan >= NUM_REQUESTERS) begin
            w_scan = w_scan - NUM_REQUESTERS;
         end
         if (!w_found && req_packet[PTR_W'(w_scan)].valid) begin
            w_found  = 1'b1;
            w_winner = PTR_W'(w_scan);
         end
      end
   end

   // Pointer advances past the winner, wrapping to requester 0.
   assign w_next_ptr = (w_winner == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : w_winner + PTR_W'(1);

   // Same-cycle accept strobe to the winner; forced low while in reset.
   always_comb begin
      req_ready = '0;
      if (reset_n && w_can_load && w_found) begin
         req_ready[w_winner] = 1'b1;
      end
   end

   // Winner packet restamped with this core's id and marked valid.
   always_comb begin
      w_load_pkt       = req_packet[w_winner];
      w_load_pkt.core  = CORE_W'(CORE_ID);
      w_load_pkt.valid = 1'b1;
   end

   // Output register and round-robin pointer; held while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out    <= '0;
         r_rr_ptr <= '0;
      end else if (w_can_load) begin
         if (w_found) begin
            r_out    <= w_load_pkt;
            r_rr_ptr <= w_next_ptr;
         end else begin
            r_out.valid <= 1'b0;
         end
      end
   end

   assign l2req_packet = r_out;

`ifndef SYNTHESIS
   // At most one requester is accepted per cycle.
   a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(req_ready));

   // Never accept a requester that is not presenting a request.
   a_ready_valid : assert property (@(posedge clk) disable iff (!reset_n)
      (req_ready & ~w_valid) == '0);

   // A held, unaccepted packet must not change.
   a_out_stable : assert property (@(posedge clk) disable iff (!reset_n)
      (r_out.valid && !l2req_ready) |=> $stable(r_out));
`endif

endmodule

// File: tb/tb_l2_request_port_arbiter.sv
// Bench for l2_request_port_arbiter: directed scenarios plus random traffic
// checked against a round-robin reference model.

module tb_l2_request_port_arbiter;
   import l2_request_port_arbiter_pkg::*;

   localparam int unsigned N    = 3;
   localparam int unsigned CORE = 5;

   logic                 clk = 1'b0;
   logic                 reset_n;
   l2req_packet_t [N-1:0] req_packet;
   logic [N-1:0]         req_ready;
   l2req_packet_t        l2req_packet;
   logic                 l2req_ready;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: the packet the L2 should see and the next search start.
   l2req_packet_t m_out;
   int            m_ptr;

   logic [N-1:0] rr_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   l2_request_port_arbiter #(
      .NUM_REQUESTERS (N),
      .CORE_ID        (CORE)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_packet   (req_packet),
      .req_ready    (req_ready),
      .l2req_packet (l2req_packet),
      .l2req_ready  (l2req_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic l2req_packet_t rand_pkt(input int unsigned u, input logic v);
      l2req_packet_t p;
      p.valid = v;
      p.core  = CORE_W'($urandom);
      p.unit  = UNIT_W'(u);
      p.cmd   = CMD_W'($urandom);
      p.addr  = $urandom;
      return p;
   endfunction

   task automatic drive(input logic [N-1:0] vmask, input logic rdy);
      for (int i = 0; i < N; i++) req_packet[i] = rand_pkt(i, vmask[i]);
      l2req_ready = rdy;
   endtask

   // One cycle: compare against the model, advance the model, move to next negedge.
   task automatic step();
      int           winner;
      int           idx;
      logic         can_load;
      logic [N-1:0] exp_ready;
      #1;
      winner    = -1;
      exp_ready = '0;
      can_load  = 1'b0;
      if (!reset_n) begin
         m_out = '0;
         m_ptr = 0;
      end else begin
         can_load = !m_out.valid || l2req_ready;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (winner < 0 && req_packet[2'(idx)].valid) winner = idx;
         end
         if (can_load && winner >= 0) exp_ready[2'(winner)] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("l2req_packet", 64'(l2req_packet), 64'(m_out));
      chk("rr_ptr", 64'(dut.r_rr_ptr), 64'(m_ptr));
      if (reset_n && can_load) begin
         if (winner >= 0) begin
            m_out       = req_packet[2'(winner)];
            m_out.core  = CORE_W'(CORE);
            m_out.valid = 1'b1;
            m_ptr       = (winner + 1) % N;
         end else begin
            m_out.valid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      m_out   = '0;
      m_ptr   = 0;
      reset_n = 1'b0;
      drive(3'b111, 1'b0);
      @(negedge clk);

      // Reset held with every requester valid: nothing accepted, output empty.
      step();
      drive(3'b111, 1'b1);
      step();
      reset_n = 1'b1;

      // Round robin with all valid; unit on the output lags the grant by one cycle.
      for (int k = 0; k < 6; k++) begin
         drive(3'b111, 1'b1);
         #1;
         chk("rr_grant", 64'(req_ready), 64'(rr_seq[k]));
         if (k > 0) begin
            chk("rr_unit", 64'(l2req_packet.unit), 64'((k - 1) % 3));
            chk("rr_core", 64'(l2req_packet.core), 64'(CORE));
         end
         step();
      end

      // Backpressure: stall four cycles, then grant in the releasing cycle.
      for (int k = 0; k < 4; k++) begin
         drive(3'b111, 1'b0);
         step();
      end
      drive(3'b111, 1'b1);
      #1;
      chk("bp_release_grant", 64'(req_ready), 64'(3'b001));
      step();

      // Wrap and skip: pointer at 2 with only 1 valid, then 0 and 2 valid.
      drive(3'b010, 1'b1);
      step();
      drive(3'b010, 1'b1);
      #1;
      chk("skip_grant", 64'(req_ready), 64'(3'b010));
      step();
      drive(3'b101, 1'b1);
      #1;
      chk("wrap_grant", 64'(req_ready), 64'(3'b100));
      step();

      // Idle drain: single packet held until accepted, then slot empties.
      drive(3'b000, 1'b1);
      step();
      drive(3'b001, 1'b1);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(3'b000, 1'b0);
         step();
      end
      drive(3'b000, 1'b1);
      step();
      drive(3'b000, 1'b1);
      step();

      // Mid-operation reset while stalled: packet dropped at once, never reissued.
      drive(3'b010, 1'b1);
      step();
      drive(3'b111, 1'b0);
      step();
      drive(3'b111, 1'b0);
      step();
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(l2req_packet.valid), 64'(0));
      chk("async_reset_ready", 64'(req_ready), 64'(0));
      step();
      reset_n = 1'b1;
      drive(3'b000, 1'b1);
      step();
      drive(3'b000, 1'b1);
      step();

      // Random traffic: requesters raise and drop freely, L2 stalls at random.
      for (int k = 0; k < 400; k++) begin
         drive(N'($urandom), ($urandom % 4) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/l2_request_port_arbiter.md
L2_REQUEST_PORT_ARBITER -- requirements
Module: l2_request_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_REQUESTERS, 3, number of L1-side request sources (icache miss queue, store buffer, dcache miss queue).
  CORE_ID, 0, core identifier stamped into every issued packet.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all state on rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  req_packet  input  l2req_packet_t x NUM_REQUESTERS  per-requester request; its .valid field is the request line.
  req_ready  output  NUM_REQUESTERS  per-requester accept strobe; packet taken this cycle.
  l2req_packet  output  l2req_packet_t  registered request to the L2 cache.
  l2req_ready  input  1  L2 takes l2req_packet this cycle when l2req_packet.valid is 1.
REQ-003 The module SHALL contain no other clocks, resets or ports.

Function
REQ-004 The block SHALL hold one output register (out_reg) driving l2req_packet, plus a round-robin pointer (rr_ptr) of clog2(NUM_REQUESTERS) bits, minimum 1 bit.
REQ-005 Slot free (can_load) SHALL be: !out_reg.valid || l2req_ready.
REQ-006 Winner SHALL be the first requester i with req_packet[i].valid, searching from rr_ptr upward and wrapping from NUM_REQUESTERS-1 to 0.
REQ-007 req_ready[winner] SHALL be 1, combinationally in the same cycle, only when can_load is 1 and a winner exists.
REQ-008 All other req_ready bits SHALL be 0.
REQ-009 req_ready SHALL be zero or one-hot.
REQ-010 req_ready SHALL never be 1 for a requester whose .valid is 0.
REQ-011 On a cycle with can_load and a winner, the next edge SHALL load out_reg with the winner's packet unchanged, except that .core SHALL be CORE_ID and .valid SHALL be 1.
REQ-012 On that same edge, rr_ptr SHALL become winner+1; after winner NUM_REQUESTERS-1 it SHALL become 0.
REQ-013 On a cycle with can_load and no valid requester, the next edge SHALL clear out_reg.valid and leave rr_ptr unchanged.
REQ-014 On a cycle with out_reg.valid=1 and l2req_ready=0, every field of l2req_packet SHALL stay stable and rr_ptr SHALL stay unchanged.
REQ-015 Latency SHALL be one cycle from req_ready[i]=1 to the packet appearing on l2req_packet.
REQ-016 Back-to-back issue SHALL be supported: with l2req_ready held at 1, one packet SHALL be accepted every cycle, for a throughput of 1/cycle.
REQ-017 Simultaneous events are defined as follows: when l2req_ready drains out_reg in the same cycle a new winner is accepted, the new packet SHALL replace out_reg with no bubble.
REQ-018 Requesters MAY drop .valid without having received req_ready; the arbiter SHALL keep no per-requester state.
REQ-019 Fairness: with all requesters continuously valid, each SHALL be granted exactly once in every NUM_REQUESTERS consecutive accepts.
REQ-020 In simulation, an assertion SHALL flag more than one req_ready bit set, and SHALL flag l2req_packet changing while valid and not accepted.

Reset
REQ-021 While reset_n=0, out_reg SHALL be all zeros (l2req_packet.valid=0), rr_ptr SHALL be 0 and req_ready SHALL be all zeros, regardless of inputs.
REQ-022 Reset asserted mid-transfer SHALL drop any held packet with no later issue of it.
REQ-023 The first accept after reset_n rises SHALL start the priority search at requester 0.

Verification
REQ-024 Reset check: hold reset_n=0 with all requesters valid -> req_ready=000 and l2req_packet.valid=0; release -> requester 0 is accepted first and appears on the output the next cycle with .core=CORE_ID.
REQ-025 Round-robin check: all 3 valid and l2req_ready=1 for 6 cycles -> req_ready sequence is 001,010,100,001,010,100, and l2req_packet.unit follows one cycle later.
REQ-026 Backpressure check: l2req_ready=0 for 4 cycles with out_reg full -> req_ready=000 and l2req_packet stable; l2req_ready=1 -> the new winner is accepted in that same cycle with no bubble.
REQ-027 Wrap and skip check: rr_ptr=2 with only requester 1 valid -> requester 1 is granted and rr_ptr becomes 2; then rr_ptr=2 with requesters 0 and 2 valid -> requester 2 is granted and rr_ptr becomes 0.
REQ-028 Idle drain check: a single packet is accepted, then no requests -> l2req_packet.valid=1 until l2req_ready, then 0 the next cycle, and rr_ptr is unchanged by the idle cycles.
REQ-029 Mid-operation reset check: out_reg valid and stalled, then reset_n pulsed low -> l2req_packet.valid=0 immediately (asynchronous) and the packet is never re-issued.
